// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Elastic pipeline register with a one-entry skid buffer, placed between
//   pipeline stages that can stall. Both handshake outputs are decoded from
//   the state register only, so backpressure never forms a combinational path
//   from out_ready to in_ready. When the register is empty, out_data shows
//   default_data, which acts as a bubble (NOP).
//
//   Ports
//     clk           rising-edge clock
//     rst           synchronous reset, active low
//     flush         drop every held entry (branch/exception kill)
//     default_data  bubble value loaded into the main register when empty
//     in_valid      producer has data
//     in_ready      an entry is free this cycle (state-decoded)
//     in_data       producer data
//     out_valid     out_data holds a valid entry
//     out_ready     consumer accepts out_data this cycle
//     out_data      head entry (main register)
//     level         number of entries held, 0..2
module pipe_skid_reg #(
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [DataWidth-1:0] default_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] out_data,
    output logic [1:0]           level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Selects what the main register is loaded with at the next edge.
    typedef enum logic [1:0] {
        MAIN_HOLD = 2'd0,
        MAIN_IN   = 2'd1,
        MAIN_SKID = 2'd2,
        MAIN_DFLT = 2'd3
    } main_sel_t;

    state_t                 state;
    state_t                 state_nxt;
    main_sel_t              main_sel;
    logic                   skid_load;
    logic [DataWidth-1:0]   main_q;
    logic [DataWidth-1:0]   skid_q;
    logic                   in_fire;
    logic                   out_fire;

    // Fire signals use the state-decoded handshake outputs.
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register. Reset wins over flush, flush wins over any handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath-control logic.
    always_comb begin
        state_nxt = state;
        main_sel  = MAIN_HOLD;
        skid_load = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt = BUSY;
                    main_sel  = MAIN_IN;
                end else begin
                    // Keep tracking default_data so the bubble follows it.
                    main_sel  = MAIN_DFLT;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_sel  = MAIN_IN;
                end else if (in_fire) begin
                    state_nxt = FULL;
                    skid_load = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                    main_sel  = MAIN_DFLT;
                end
            end
            FULL: begin
                // in_ready is low here, so in_valid cannot fire.
                if (out_fire) begin
                    state_nxt = BUSY;
                    main_sel  = MAIN_SKID;
                end
            end
            default: begin
                state_nxt = EMPTY;
                main_sel  = MAIN_DFLT;
            end
        endcase
    end

    // Output decode, from the state register only.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        level     = 2'd0;
        unique case (state)
            EMPTY: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
                level     = 2'd0;
            end
            BUSY: begin
                out_valid = 1'b1;
                in_ready  = 1'b1;
                level     = 2'd1;
            end
            FULL: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
                level     = 2'd2;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
                level     = 2'd0;
            end
        endcase
    end

    // Main register: reset and flush both load the bubble value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_q <= default_data;
        end else if (flush) begin
            main_q <= default_data;
        end else begin
            unique case (main_sel)
                MAIN_IN:   main_q <= in_data;
                MAIN_SKID: main_q <= skid_q;
                MAIN_DFLT: main_q <= default_data;
                default:   main_q <= main_q;
            endcase
        end
    end

    // Skid register: its contents only matter in FULL, so no reset or flush.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_q <= in_data;
        end
    end

    assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] NOP = 32'h0000_0013;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [DW-1:0] default_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    level;

    int tests_run    = 0;
    int tests_failed = 0;
    bit mon_en       = 0;

    logic [DW-1:0] sb_q[$];

    pipe_skid_reg #(.DataWidth(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .default_data (default_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: checks state against the model size, then applies
    // the handshakes that will take effect at the coming rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            int sz;
            logic [DW-1:0] exp_d;
            bit ifire;
            bit ofire;
            sz = sb_q.size();
            tests_run++;
            if ({30'b0, level} !== sz || out_valid !== (sz != 0) || in_ready !== (sz < 2)) begin
                tests_failed++;
                $display("FAIL sb_state: level=%0d out_valid=%b in_ready=%b, required level=%0d out_valid=%b in_ready=%b",
                         level, out_valid, in_ready, sz, (sz != 0), (sz < 2));
            end
            ifire = in_valid && (sz < 2);
            ofire = out_ready && (sz != 0);
            if (!rst || flush) begin
                sb_q.delete();
            end else begin
                if (ofire) begin
                    exp_d = sb_q.pop_front();
                    tests_run++;
                    if (out_data !== exp_d) begin
                        tests_failed++;
                        $display("FAIL sb_data: out_data=%h required %h", out_data, exp_d);
                    end
                end
                if (ifire) sb_q.push_back(in_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_ready = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        default_data = NOP;
        rst = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || level !== 2'd0 || out_data !== NOP) begin
            tests_failed++;
            $display("FAIL reset: out_valid=%b in_ready=%b level=%0d out_data=%h, required 0 1 0 %h",
                     out_valid, in_ready, level, out_data, NOP);
        end
        rst = 1'b1;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            tick();
            tests_run++;
            if (out_data !== DW'(i) || level !== 2'd1 || in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_%0d: out_data=%h level=%0d in_ready=%b, required %h 1 1",
                         i, out_data, level, in_ready, DW'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (level !== 2'd0 || out_data !== NOP) begin
            tests_failed++;
            $display("FAIL stream_drain: level=%0d out_data=%h, required 0 %h", level, out_data, NOP);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; tick();
        in_data = 32'hB; tick();
        in_data = 32'hC; tick();
        tests_run++;
        if (level !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
            tests_failed++;
            $display("FAIL bp_full: level=%0d in_ready=%b out_data=%h, required 2 0 a", level, in_ready, out_data);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_data !== 32'hB || level !== 2'd1) begin
            tests_failed++;
            $display("FAIL bp_pop1: out_data=%h level=%0d, required b 1", out_data, level);
        end
        tick();
        tests_run++;
        if (out_data !== 32'hC || level !== 2'd1) begin
            tests_failed++;
            $display("FAIL bp_pop2: out_data=%h level=%0d, required c 1", out_data, level);
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (level !== 2'd0) begin
            tests_failed++;
            $display("FAIL bp_empty: level=%0d required 0", level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_simul_fire();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h5; tick();
        out_ready = 1'b1; in_data = 32'h6; tick();
        tests_run++;
        if (out_data !== 32'h6 || level !== 2'd1) begin
            tests_failed++;
            $display("FAIL simul_fire: out_data=%h level=%0d, required 6 1", out_data, level);
        end
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; tick();
        in_data = 32'h22; tick();
        flush = 1'b1; in_data = 32'h33; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tests_run++;
        if (level !== 2'd0 || out_valid !== 1'b0 || out_data !== default_data) begin
            tests_failed++;
            $display("FAIL flush: level=%0d out_valid=%b out_data=%h, required 0 0 %h",
                     level, out_valid, out_data, default_data);
        end
        repeat (3) tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_later: out_valid=%b required 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h44; tick();
        in_data = 32'h55; tick();
        rst = 1'b0; flush = 1'b0; in_data = 32'h66;
        tick();
        rst = 1'b1; in_valid = 1'b0;
        tests_run++;
        if (level !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== default_data) begin
            tests_failed++;
            $display("FAIL reset_mid: level=%0d in_ready=%b out_valid=%b out_data=%h, required 0 1 0 %h",
                     level, in_ready, out_valid, out_data, default_data);
        end
    endtask

    task automatic test_default_change();
        default_data = 32'h0000_0055;
        tick();
        tests_run++;
        if (out_data !== 32'h0000_0055) begin
            tests_failed++;
            $display("FAIL default_change: out_data=%h required 00000055", out_data);
        end
        default_data = NOP;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;
        drain();
        tests_run++;
        if (level !== 2'd0 || sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_drain: level=%0d model=%0d, required 0 0", level, sb_q.size());
        end
    endtask

    initial begin
        rst = 1'b0;
        default_data = NOP;
        idle_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_simul_fire();
        test_flush();
        test_reset_mid();
        test_default_change();
        test_back_to_back();
        mon_en = 1'b0;
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
